// File: rtl/cpu_stage_sequencer_if.sv
// Program-load stream interface for cpu_stage_sequencer.
// The master is the stream source (drives valid/data/last); the slave is the
// sequencer, which returns ready.
interface cpu_stage_sequencer_if #(
    parameter int INSTR_W = 12
);
    logic               ld_valid;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;
    logic               ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/cpu_stage_sequencer.sv
// CPU stage sequencer: owns the program-load phase and then cycles
// FETCH -> DECODE -> EXECUTE, with start/halt control at instruction
// boundaries. core_en qualifies every core register/memory enable.
// Optional feature macro: SINGLE_STEP_EN (step pulse in HALT runs exactly one
// instruction and returns to HALT). Without it, step is ignored.
module cpu_stage_sequencer #(
    parameter int PMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 12,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  run_start,
    input  logic                  halt_req,
    input  logic                  step,
    cpu_stage_sequencer_if.slave  ld,
    output logic [1:0]            stage,
    output logic                  core_en,
    output logic [ADDR_W-1:0]     load_addr,
    output logic [INSTR_W-1:0]    load_instr,
    output logic                  load_done,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_DECODE  = 3'd3;
    localparam logic [2:0] S_EXECUTE = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);

    logic [2:0]         state_reg, state_next;
    logic [1:0]         stage_reg, stage_next;
    logic [ADDR_W-1:0]  load_addr_reg, load_addr_next;
    logic               load_done_reg, load_done_next;
    logic [CNT_W-1:0]   instr_count_reg, instr_count_next;
    logic               running_reg, running_next;
    logic               halted_reg, halted_next;
    logic               step_mode_reg, step_mode_next;
    logic               handshake;

`ifndef SINGLE_STEP_EN
    // step has no effect in this build; keep it visibly consumed
    logic unused_step;
    assign unused_step = step;
`endif

    // Load words are only accepted while in LOAD; this also blocks any
    // word beyond the last program memory address.
    assign ld.ld_ready = (state_reg == S_LOAD);
    assign handshake   = ld.ld_valid && (state_reg == S_LOAD);
    assign load_instr  = ld.ld_data;

    // Core enable: every run stage, or a load handshake (memory write)
    always_comb begin
        core_en = 1'b0;
        case (state_reg)
            S_LOAD:                       core_en = handshake;
            S_FETCH, S_DECODE, S_EXECUTE: core_en = 1'b1;
            default:                      core_en = 1'b0;
        endcase
    end

    // Next-state, load address, counter and stage-derived status
    always_comb begin
        state_next       = state_reg;
        load_addr_next   = load_addr_reg;
        load_done_next   = 1'b0;
        instr_count_next = instr_count_reg;
        step_mode_next   = step_mode_reg;
        case (state_reg)
            S_IDLE, S_HALT: begin
                if (load_start) begin
                    state_next       = S_LOAD;
                    load_addr_next   = '0;
                    instr_count_next = '0;
                    step_mode_next   = 1'b0;
                end else if (run_start) begin
                    state_next     = S_FETCH;
                    step_mode_next = 1'b0;
                end
`ifdef SINGLE_STEP_EN
                else if (step && (state_reg == S_HALT)) begin
                    state_next     = S_FETCH;
                    step_mode_next = 1'b1;
                end
`endif
            end
            S_LOAD: begin
                if (handshake) begin
                    if (ld.ld_last || (load_addr_reg == LAST_ADDR)) begin
                        state_next     = S_IDLE;
                        load_done_next = 1'b1;
                    end else begin
                        load_addr_next = load_addr_reg + ADDR_W'(1);
                    end
                end
            end
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXECUTE;
            S_EXECUTE: begin
                if (!(&instr_count_reg)) begin
                    instr_count_next = instr_count_reg + CNT_W'(1);
                end
                // A single-stepped instruction always parks in HALT
                if (step_mode_reg || halt_req) begin
                    state_next     = S_HALT;
                    step_mode_next = 1'b0;
                end else begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_FETCH:   stage_next = 2'b01;
            S_DECODE:  stage_next = 2'b10;
            S_EXECUTE: stage_next = 2'b11;
            default:   stage_next = 2'b00;
        endcase
        running_next = (state_next == S_FETCH) || (state_next == S_DECODE) ||
                       (state_next == S_EXECUTE);
        halted_next  = (state_next == S_HALT);
    end

    // State and registered outputs; reset takes effect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            stage_reg       <= 2'b00;
            load_addr_reg   <= '0;
            load_done_reg   <= 1'b0;
            instr_count_reg <= '0;
            running_reg     <= 1'b0;
            halted_reg      <= 1'b0;
            step_mode_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            stage_reg       <= stage_next;
            load_addr_reg   <= load_addr_next;
            load_done_reg   <= load_done_next;
            instr_count_reg <= instr_count_next;
            running_reg     <= running_next;
            halted_reg      <= halted_next;
            step_mode_reg   <= step_mode_next;
        end
    end

    assign stage       = stage_reg;
    assign load_addr   = load_addr_reg;
    assign load_done   = load_done_reg;
    assign instr_count = instr_count_reg;
    assign running     = running_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer (PMEM_DEPTH=4, CNT_W=4).
// Expected core_en cycles and load_done pulses are queued as stimulus is
// issued; a negedge monitor pops and compares them. Status outputs are
// checked directly at instruction/load boundaries.
// Honours SINGLE_STEP_EN the same way as the design.
module tb_cpu_stage_sequencer;

    localparam int PMEM_DEPTH = 4;
    localparam int ADDR_W     = 8;
    localparam int INSTR_W    = 12;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic              kind;   // 0: core_en cycle, 1: load_done pulse
        logic [1:0]        stg;
        logic [ADDR_W-1:0] addr;
        logic [INSTR_W-1:0] data;
    } ev_t;

    logic               clk;
    logic               rst;
    logic               load_start;
    logic               run_start;
    logic               halt_req;
    logic               step;
    logic [1:0]         stage;
    logic               core_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_instr;
    logic               load_done;
    logic               running;
    logic               halted;
    logic [CNT_W-1:0]   instr_count;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];

    cpu_stage_sequencer_if #(.INSTR_W(INSTR_W)) bus ();

    cpu_stage_sequencer #(
        .PMEM_DEPTH(PMEM_DEPTH),
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .run_start  (run_start),
        .halt_req   (halt_req),
        .step       (step),
        .ld         (bus.slave),
        .stage      (stage),
        .core_en    (core_en),
        .load_addr  (load_addr),
        .load_instr (load_instr),
        .load_done  (load_done),
        .running    (running),
        .halted     (halted),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push_write(input int addr, input logic [INSTR_W-1:0] data);
        ev_t e;
        e.kind = 1'b0; e.stg = 2'b00; e.addr = ADDR_W'(addr); e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_stage(input logic [1:0] s);
        ev_t e;
        e.kind = 1'b0; e.stg = s; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.kind = 1'b1; e.stg = 2'b00; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_instrs(input int n);
        for (int i = 0; i < n; i++) begin
            push_stage(2'b01);
            push_stage(2'b10);
            push_stage(2'b11);
        end
    endtask

    task automatic compare_event(input ev_t act);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d stage=%0d addr=%0h data=%0h",
                     act.kind, act.stg, act.addr, act.data);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL event: got kind=%0d stage=%0d addr=%0h data=%0h expected kind=%0d stage=%0d addr=%0h data=%0h",
                         act.kind, act.stg, act.addr, act.data, e.kind, e.stg, e.addr, e.data);
            end else begin
                $display("ok   event: kind=%0d stage=%0d addr=%0h data=%0h",
                         act.kind, act.stg, act.addr, act.data);
            end
        end
    endtask

    // Monitor: every core_en cycle and every load_done pulse is an output event
    always @(negedge clk) begin
        ev_t a;
        if (!rst) begin
            if (core_en) begin
                a.kind = 1'b0;
                a.stg  = stage;
                a.addr = (stage == 2'b00) ? load_addr : '0;
                a.data = (stage == 2'b00) ? load_instr : '0;
                compare_event(a);
            end
            if (load_done) begin
                a.kind = 1'b1; a.stg = 2'b00; a.addr = '0; a.data = '0;
                compare_event(a);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, " stage"},       32'(stage),       32'd0);
        check({tag, " core_en"},     32'(core_en),     32'd0);
        check({tag, " ld_ready"},    32'(bus.ld_ready), 32'd0);
        check({tag, " load_addr"},   32'(load_addr),   32'd0);
        check({tag, " load_done"},   32'(load_done),   32'd0);
        check({tag, " running"},     32'(running),     32'd0);
        check({tag, " halted"},      32'(halted),      32'd0);
        check({tag, " instr_count"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        logic [INSTR_W-1:0] words [3];
        logic [INSTR_W-1:0] w;
        words[0] = 12'hA01; words[1] = 12'hB02; words[2] = 12'hC03;

        rst = 1'b1; load_start = 0; run_start = 0; halt_req = 0; step = 0;
        bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;

        // Power-on reset
        tick();
        check_reset_values("por");
        tick();
        rst = 1'b0;
        tick();

        // Async reset in the middle of an instruction (during EXECUTE)
        run_start = 1'b1;
        push_stage(2'b01);
        push_stage(2'b10);
        tick();
        run_start = 1'b0;
        check("run fetch stage", 32'(stage), 32'd1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check_reset_values("async");
        tick();
        rst = 1'b0;
        tick();

        // Gapped 3-word load, ld_last on word 3; run_start ignored in LOAD
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = words[i];
            bus.ld_last  = (i == 2);
            push_write(i, words[i]);
            if (i == 2) push_done();
            tick();
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
            if (i < 2) begin
                check("load gap ready", 32'(bus.ld_ready), 32'd1);
                run_start = (i == 0);
                tick();
                run_start = 1'b0;
            end
        end
        tick();
        check("load3 addr", 32'(load_addr), 32'd2);
        check("load3 ready", 32'(bus.ld_ready), 32'd0);
        check("load3 running", 32'(running), 32'd0);

        // Overflow: 6 words, no ld_last, only 4 accepted
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = 12'(12'h111 * (i + 1));
            bus.ld_valid = 1'b1;
            bus.ld_data  = w;
            bus.ld_last  = 1'b0;
            if (i < 4) push_write(i, w);
            if (i == 3) push_done();
            if (i == 4) begin
                check("ovf ready", 32'(bus.ld_ready), 32'd0);
                check("ovf addr", 32'(load_addr), 32'd3);
            end
            tick();
        end
        bus.ld_valid = 1'b0;
        tick();

        // Run three instructions, halt_req raised during DECODE of the third
        run_start = 1'b1;
        push_instrs(3);
        tick();
        run_start = 1'b0;
        check("run running", 32'(running), 32'd1);
        for (int k = 2; k <= 8; k++) tick();
        halt_req = 1'b1;
        tick();
        check("halt not in decode", 32'(stage), 32'd3);
        tick();
        halt_req = 1'b0;
        check("halt halted", 32'(halted), 32'd1);
        check("halt running", 32'(running), 32'd0);
        check("halt count", 32'(instr_count), 32'd3);

        // Single step from HALT, two pulses 10 cycles apart
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
`ifdef SINGLE_STEP_EN
            push_instrs(1);
`endif
            tick();
            step = 1'b0;
            tick();
            tick();
            tick();
            check("step halted", 32'(halted), 32'd1);
`ifdef SINGLE_STEP_EN
            check("step count", 32'(instr_count), 32'(4 + p));
`else
            check("step count", 32'(instr_count), 32'd3);
`endif
            for (int k = 0; k < 6; k++) tick();
        end

        // Same-cycle load_start + run_start in HALT: load wins, count cleared
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        check("both ready", 32'(bus.ld_ready), 32'd1);
        check("both running", 32'(running), 32'd0);
        check("both count", 32'(instr_count), 32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 12'h5A5;
        bus.ld_last  = 1'b1;
        push_write(0, 12'h5A5);
        push_done();
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        tick();

        // Saturation: 17 instructions on a 4-bit counter stop at 15
        run_start = 1'b1;
        push_instrs(17);
        tick();
        run_start = 1'b0;
        for (int k = 2; k <= 50; k++) tick();
        halt_req = 1'b1;
        tick();
        tick();
        halt_req = 1'b0;
        check("sat halted", 32'(halted), 32'd1);
        check("sat count", 32'(instr_count), 32'd15);

        repeat (3) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
